pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl.sv | 85 ++++++++
 tb/tb_pwm_ramp_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps a registered PWM duty toward an accepted target, one clamped step per paced period_end
module pwm_ramp_ctrl #(
    parameter int unsigned STEP_DIV = 1000,
    parameter int unsigned STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    input  logic [7:0] tgt_duty,
    output logic       tgt_ready,
    input  logic       period_end,
    input  logic       abort,
    output logic [7:0] cmd,
    output logic       busy,
    output logic       done
);
    typedef enum logic {IDLE, RAMP} state_t;
    localparam logic [15:0] TC = 16'(STEP_DIV - 1);
    localparam logic [8:0] ST = 9'(STEP);
    state_t state, state_d;
    logic [7:0] cmd_d, target, target_d, next;
    logic [15:0] cnt, cnt_d;
    logic pend, pend_d, done_d, up, accept, tc, consume;
    logic [8:0] diff;
    assign tgt_ready = state == IDLE && !abort && !rst;
    assign busy = state == RAMP;
    assign accept = tgt_valid && tgt_ready;
    assign tc = cnt == TC;
    assign consume = pend && period_end;
    assign up = target > cmd;
    assign diff = up ? {1'b0, target} - {1'b0, cmd} : {1'b0, cmd} - {1'b0, target};
    // clamp to target when the remaining distance fits in one step, so no overshoot or wrap
    assign next = diff <= ST ? target : up ? cmd + 8'(STEP) : cmd - 8'(STEP);
    always_comb begin
        state_d = state;
        cmd_d = cmd;
        target_d = target;
        cnt_d = cnt;
        pend_d = pend;
        done_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cmd_d = 8'd0;
            cnt_d = 16'd0;
            pend_d = 1'b0;
        end else if (state == IDLE) begin
            cnt_d = 16'd0;
            pend_d = 1'b0;
            if (accept) begin
                target_d = tgt_duty;
                done_d = tgt_duty == cmd;
                state_d = tgt_duty == cmd ? IDLE : RAMP;
            end
        end else begin
            cnt_d = tc ? 16'd0 : cnt + 16'd1;
            pend_d = tc | (pend & ~period_end);
            if (consume) begin
                cmd_d = next;
                if (next == target) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                    cnt_d = 16'd0;
                    pend_d = 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd <= 8'd0;
            target <= 8'd0;
            cnt <= 16'd0;
            pend <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_d;
            cmd <= cmd_d;
            target <= target_d;
            cnt <= cnt_d;
            pend <= pend_d;
            done <= done_d;
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scoreboarded directed test of the duty ramp controller
module tb_pwm_ramp_ctrl;
    logic clk = 1'b0, rst = 1'b1, tgt_valid = 1'b0, period_end = 1'b0, abort = 1'b0;
    logic [7:0] tgt_duty = 8'd0, cmd;
    logic tgt_ready, busy, done;
    bit pe_en = 1'b1, mon_en = 1'b0;
    int checks = 0, errors = 0;
    typedef struct {bit is_done; logic [7:0] val;} ev_t;
    ev_t q[$];

    pwm_ramp_ctrl #(.STEP_DIV(4), .STEP(10)) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_duty(tgt_duty), .tgt_ready(tgt_ready),
        .period_end(period_end), .abort(abort), .cmd(cmd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (7) @(posedge clk);
        #1 period_end = pe_en;
        @(posedge clk);
        #1 period_end = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] v);
        q.push_back('{1'b0, v});
    endtask

    task automatic push_done();
        q.push_back('{1'b1, 8'd0});
    endtask

    // monitor: every cmd change and every done pulse must match the next scoreboard entry
    initial begin
        logic [7:0] prev;
        ev_t e;
        wait (mon_en);
        prev = cmd;
        forever begin
            @(negedge clk);
            if (cmd !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_change: got %0d expected no change", cmd);
                end else begin
                    e = q.pop_front();
                    if (e.is_done || cmd !== e.val) begin
                        errors++;
                        $display("FAIL cmd_change: got cmd %0d expected %s %0d", cmd, e.is_done ? "done" : "cmd", e.val);
                    end
                end
            end
            prev = cmd;
            if (done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL done_pulse: got done expected none");
                end else begin
                    e = q.pop_front();
                    if (!e.is_done) begin
                        errors++;
                        $display("FAIL done_pulse: got done expected cmd %0d", e.val);
                    end
                end
            end
        end
    end

    task automatic accept(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!tgt_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
        tgt_valid = 1'b1;
        tgt_duty = d;
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_cmd(input logic [7:0] v);
        int n = 0;
        while (cmd != v && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("cmd_timeout", cmd, v);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ready_in_rst", tgt_ready, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_cmd", cmd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", tgt_ready, 1);

        push_cmd(10); push_cmd(20); push_cmd(25); push_done();
        accept(25);
        chk("up_busy", busy, 1);
        wait_idle();
        chk("up_final", cmd, 25);

        push_cmd(15); push_cmd(5); push_cmd(3); push_done();
        accept(3);
        chk("down_busy", busy, 1);
        wait_idle();
        chk("down_final", cmd, 3);

        push_done();
        accept(3);
        for (int i = 0; i < 3; i++) begin
            chk("eq_busy", busy, 0);
            @(negedge clk);
        end

        pe_en = 1'b0;
        repeat (2) @(negedge clk);
        push_cmd(13); push_done();
        accept(13);
        repeat (20) @(negedge clk);
        chk("pace_hold_cmd", cmd, 3);
        chk("pace_hold_busy", busy, 1);
        pe_en = 1'b1;
        wait_idle();
        chk("pace_final", cmd, 13);

        push_cmd(3); push_cmd(0); push_done();
        accept(0);
        wait_idle();
        push_cmd(10); push_cmd(20); push_cmd(30); push_cmd(40); push_cmd(50); push_cmd(0);
        accept(200);
        wait_cmd(50);
        abort = 1'b1;
        tgt_valid = 1'b1;
        tgt_duty = 8'd77;
        @(negedge clk);
        abort = 1'b0;
        tgt_valid = 1'b0;
        chk("abort_cmd", cmd, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("abort_not_accepted", busy, 0);
        push_cmd(10); push_cmd(20); push_done();
        accept(20);
        wait_idle();
        chk("post_abort_final", cmd, 20);

        push_cmd(30); push_cmd(40); push_cmd(50); push_cmd(60);
        push_cmd(70); push_cmd(80); push_cmd(90); push_cmd(100); push_done();
        accept(100);
        wait_idle();
        push_cmd(90); push_cmd(80); push_cmd(70); push_cmd(60); push_cmd(50);
        push_cmd(40); push_cmd(30); push_cmd(0);
        accept(0);
        wait_cmd(30);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cmd", cmd, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", tgt_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", tgt_ready, 1);
        repeat (30) @(negedge clk);
        chk("post_rst_idle", busy, 0);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
